// File: rtl/ca_actuator_responder_if.sv
// Command/sensor bundle between the sequencing controller and the actuator responder.
interface ca_actuator_responder_if;
    logic [1:0] ca;
    logic       start_btn;
    logic [1:0] act;
    logic       c1;
    logic       c2;
    logic       i_req;
    logic       busy;
    logic       err;

    // Controller / field side: issues commands and the raw button, observes sensors.
    modport master (
        output ca,
        output start_btn,
        input  act,
        input  c1,
        input  c2,
        input  i_req,
        input  busy,
        input  err
    );

    // Responder side: consumes commands, drives actuators and sensor levels.
    modport slave (
        input  ca,
        input  start_btn,
        output act,
        output c1,
        output c2,
        output i_req,
        output busy,
        output err
    );
endinterface

// File: rtl/ca_actuator_responder.sv
// Actuator responder: two timed-stroke channels plus a debounced start request.
module ca_actuator_responder #(
    parameter int unsigned STROKE_CYCLES   = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    ca_actuator_responder_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STROKE_CYCLES + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DONE   = 2'd2
    } ch_state_e;

    ch_state_e        st_q  [2];
    ch_state_e        st_d  [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       act_q, act_d;
    logic [1:0]       c_q, c_d;
    logic             err_q, err_d;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [DB_W-1:0]  dcnt_q, dcnt_d;
    logic             i_req_q, i_req_d;

    // Channel next-state: stroke timing, abort detection, outputs decoded from next state.
    always_comb begin
        err_d = err_q;
        act_d = '0;
        c_d   = '0;
        for (int n = 0; n < 2; n++) begin
            st_d[n]  = st_q[n];
            cnt_d[n] = cnt_q[n];
            case (st_q[n])
                ST_IDLE: begin
                    if (bus.ca[n]) begin
                        st_d[n]  = ST_MOVING;
                        cnt_d[n] = '0;
                    end
                end
                ST_MOVING: begin
                    // A dropped command aborts even on the final count.
                    if (!bus.ca[n]) begin
                        st_d[n] = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (cnt_q[n] == CNT_W'(STROKE_CYCLES - 1)) begin
                        st_d[n] = ST_DONE;
                    end else begin
                        cnt_d[n] = cnt_q[n] + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!bus.ca[n]) begin
                        st_d[n] = ST_IDLE;
                    end
                end
                default: begin
                    st_d[n] = ST_IDLE;
                end
            endcase
            act_d[n] = (st_d[n] == ST_MOVING);
            c_d[n]   = (st_d[n] == ST_DONE);
        end
    end

    // Button synchronizer and debounce counter; i_req toggles after a stable run.
    always_comb begin
        s1_d    = bus.start_btn;
        s2_d    = s1_q;
        dcnt_d  = '0;
        i_req_d = i_req_q;
        if (s2_q != i_req_q) begin
            if (dcnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                i_req_d = ~i_req_q;
            end else begin
                dcnt_d = dcnt_q + DB_W'(1);
            end
        end
    end

    // State register for both channels and the debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                st_q[n]  <= ST_IDLE;
                cnt_q[n] <= '0;
            end
            act_q   <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dcnt_q  <= '0;
            i_req_q <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                st_q[n]  <= st_d[n];
                cnt_q[n] <= cnt_d[n];
            end
            act_q   <= act_d;
            c_q     <= c_d;
            err_q   <= err_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dcnt_q  <= dcnt_d;
            i_req_q <= i_req_d;
        end
    end

    // Output mapping; busy is the only combinational output.
    assign bus.act   = act_q;
    assign bus.c1    = c_q[0];
    assign bus.c2    = c_q[1];
    assign bus.err   = err_q;
    assign bus.i_req = i_req_q;
    assign bus.busy  = (st_q[0] == ST_MOVING) || (st_q[1] == ST_MOVING);

endmodule
